decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary-to-one-hot decoder that generalises the fixed 4-to-12 decoder to any input width and output count. Adds a valid/ready input handshake, a registered output with `out_valid`, out-of-range error flagging, and a self-timed scan mode that walks a single active output across all positions. It sits between control logic and one-hot consumers such as LED/anode multiplexers, register-bank selects and channel enables.

## Interface
- `IN_W`, 4, code width in bits; ≥1.
- `OUT_N`, 12, number of one-hot outputs; 2 ≤ `OUT_N` ≤ 2**`IN_W`.
- `DWELL`, 4, cycles each position is held in scan mode; ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = direct decode, 1 = scan; sampled every cycle.
- `in_valid`  in  1  `in_code` is valid.
- `in_code`  in  `IN_W`  binary code.
- `in_ready`  out  1  code is accepted when `in_valid && in_ready`.
- `O`  out  `OUT_N`  one-hot output, indexed `[0:OUT_N-1]`; `O[0]` corresponds to code 0.
- `out_valid`  out  1  `O` holds a decoded or scan value.
- `err`  out  1  last accepted code was ≥ `OUT_N`.
- `scan_pos`  out  `$clog2(OUT_N)`  current active index in scan mode; 0 otherwise.

## Operation
- States: `IDLE`, `HOLD`, `SCAN`.
- `IDLE`: `O` = 0, `out_valid` = 0, `in_ready` = 1.
  - Accept with `mode`=0 -> `HOLD`.
  - `mode`=1 -> `SCAN`.
- `HOLD`: `O` is the one-hot of the latched code; `in_ready` = 1.
  - A new accept replaces the code.
  - `mode`=1 -> `SCAN`.
- Out-of-range accept (code ≥ `OUT_N`): `O` = 0, `out_valid` = 1, `err` = 1.
  - `err` holds until the next accept with an in-range code, or until reset.
- `SCAN`: `in_ready` = 0.
  - `O` = one-hot of `scan_pos`.
  - `scan_pos` advances every `DWELL` cycles and wraps from `OUT_N`-1 to 0.
  - `out_valid` = 1.
  - `mode`=0 -> `IDLE`.
- Entering `SCAN` always starts at position 0 with a fresh dwell count.
- Leaving `SCAN` clears `O`, `scan_pos` and the dwell counter.
- `err` is unchanged by mode changes.
- Dwell counter: 0..`DWELL`-1. The position advances on the cycle the counter equals `DWELL`-1. With `DWELL`=1 the position advances every cycle.
- Simultaneous `mode`=1 and an accept in `IDLE`/`HOLD`: the mode change wins. The code is accepted (`in_ready` is still 1 that cycle) but discarded. `err` is not updated.
- Exactly one bit of `O` is set whenever `out_valid` = 1 and `err` = 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state `IDLE`; `O` = 0, `out_valid` = 0, `err` = 0, `scan_pos` = 0.
  - `in_ready` = 1 from the first cycle after reset release.
- Direct latency: an accept at edge N makes `O`, `out_valid` and `err` valid after edge N. Throughput is one code per cycle.
- Scan latency: `mode` rises before edge N -> `O[0]` = 1 after edge N. `O[1]` = 1 after edge N+`DWELL`.
- `mode` falls before edge N -> `O` = 0, `out_valid` = 0 after edge N.
- Reset asserted mid-scan or mid-hold: all outputs return to reset values immediately, without waiting for a clock.
- All outputs are registered; no combinational path from inputs to outputs except `in_ready`, which is decoded from state only.

## Configuration
- `DECODER_SCAN_ACTIVE_LOW_EN`:
  - Defined: `O` is inverted at the register output, so the active position is 0 and inactive positions are 1. The reset value of `O` is all ones. This suits common-anode display drivers.
  - Undefined: `O` is active-high as described above.
- `out_valid`, `err` and `scan_pos` are unaffected by the macro.

## Structure
- Package `decoder_pkg`:
  - state enum (`IDLE`, `HOLD`, `SCAN`);
  - mode constants `MODE_DIRECT`=0, `MODE_SCAN`=1.
- Sub-module `onehot_dec`: purely combinational, parametrised `IN_W`/`OUT_N`. Outputs the one-hot vector plus an out-of-range flag. It is instantiated once, fed by a mux of the latched code and `scan_pos`.
- The top level holds the FSM, dwell counter, position counter and output registers.

## Test plan
- Reset, then direct mode with `IN_W`=4, `OUT_N`=12. Accept codes 0, 5, 11 back-to-back -> after each edge `O` = 1000_0000_0000, 0000_0100_0000, 0000_0000_0001, with `out_valid`=1 and `err`=0.
- Accept code 13 -> `O` = 0, `err` = 1. Then accept code 2 -> `O` = 0010_0000_0000, `err` = 0.
- `mode`=1 with `DWELL`=3 -> `O[0]` is high for 3 cycles, then `O[1]`, and so on. After 36 cycles the sequence wraps to `O[0]`. `in_ready` = 0 throughout.
- `mode` falls while `scan_pos`=7 -> next cycle `O` = 0, `out_valid` = 0, `scan_pos` = 0. A new accept of code 4 -> `O` = 0000_1000_0000.
- Assert `reset_n` low asynchronously mid-scan (between edges) -> `O`, `out_valid` and `err` clear immediately. After release, `in_ready` = 1.
- Build with `DECODER_SCAN_ACTIVE_LOW_EN` and accept code 3 -> `O` = 1110_1111_1111. The reset value of `O` is all ones.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the parametrised one-hot decoder with scan mode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, mode encodings, counter-width helper.
package decoder_pkg;

  // Controller states: idle (outputs dark), holding a decoded code, scanning.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  // Encodings of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a counter that must hold 0..n-1; never returns zero so a
  // single-value counter still has a legal (constant) register.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with out-of-range flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows the input code every cycle.
// Ports: code_i (binary code), oh_o[0:OUT_N-1] (oh_o[k] set for code k),
//        oor_o (code_i >= OUT_N; oh_o is all zero in that case).
module onehot_dec #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 12
) (
  input  logic [IN_W-1:0]  code_i,
  output logic [0:OUT_N-1] oh_o,
  output logic             oor_o
);

  always_comb begin
    oh_o = '0;
    for (int i = 0; i < OUT_N; i++) begin
      if (code_i == IN_W'(i)) begin
        oh_o[i] = 1'b1;
      end
    end
  end

  // One extra bit so the compare is valid when OUT_N == 2**IN_W.
  assign oor_o = ({1'b0, code_i} >= (IN_W + 1)'(OUT_N));

endmodule : onehot_dec

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with valid/ready input, error flag
// and a self-timed scan mode that walks one active output across OUT_N.
// Latency: 1 cycle from accept (or mode change) to O/out_valid/err.
// Backpressure: in_ready = 1 in IDLE/HOLD (one code per cycle), 0 in SCAN.
// Ports: clk, reset_n (async active-low), mode (0 direct, 1 scan),
//        in_valid/in_code/in_ready (input handshake), O[0:OUT_N-1] (one-hot,
//        O[0] = code 0), out_valid, err (last accepted code >= OUT_N),
//        scan_pos (active index while scanning, else 0).
// Build option: define DECODER_SCAN_ACTIVE_LOW_EN for an active-low O
// (reset value all ones); out_valid, err and scan_pos are unaffected.
module decoder_scan #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 12,
  parameter int DWELL = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_code,
  output logic                     in_ready,
  output logic [0:OUT_N-1]         O,
  output logic                     out_valid,
  output logic                     err,
  output logic [$clog2(OUT_N)-1:0] scan_pos
);

  import decoder_pkg::*;

  localparam int PW = $clog2(OUT_N);
  localparam int DW = cnt_w(DWELL);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(OUT_N - 1);

  // XOR mask applied before the output register, so the flop itself holds
  // the pin value and the reset value follows the polarity.
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [0:OUT_N-1] O_POL = '1;
`else
  localparam logic [0:OUT_N-1] O_POL = '0;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [IN_W-1:0] code_q,  code_d;
  logic [PW-1:0]   pos_q,   pos_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [0:OUT_N-1] o_q,    o_d;
  logic            ov_q,    ov_d;
  logic            err_q,   err_d;

  logic             accept;
  logic             direct_accept;
  logic [IN_W-1:0]  dec_code;
  logic [0:OUT_N-1] dec_oh;
  logic             dec_oor;

  // Ready is a pure function of state: no input-to-output path.
  assign in_ready = (state_q != SCAN);
  assign accept   = in_valid && in_ready;

  // An accept only takes effect when it does not coincide with a switch
  // into scan mode; otherwise the code is consumed and dropped.
  assign direct_accept = accept && (mode == MODE_DIRECT);

  // ---------------------------------------------------------------------
  // FSM, latched code, dwell and position counters
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pos_d   = pos_q;
    dwell_d = dwell_q;

    unique case (state_q)
      IDLE, HOLD: begin
        if (mode == MODE_SCAN) begin
          state_d = SCAN;
          pos_d   = '0;
          dwell_d = '0;
        end else if (direct_accept) begin
          state_d = HOLD;
          code_d  = in_code;
        end
      end

      SCAN: begin
        if (mode == MODE_DIRECT) begin
          state_d = IDLE;
          pos_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          // Last cycle of this dwell: move on, wrapping after OUT_N-1.
          dwell_d = '0;
          pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        pos_d   = '0;
        dwell_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Single shared decoder, fed with the value the output register will
  // represent next cycle so O lines up with state_d.
  // ---------------------------------------------------------------------
  assign dec_code = (state_d == SCAN) ? IN_W'(pos_d) : code_d;

  onehot_dec #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .code_i (dec_code),
    .oh_o   (dec_oh),
    .oor_o  (dec_oor)
  );

  // ---------------------------------------------------------------------
  // Output next-state. An out-of-range code decodes to all zeros, which
  // is exactly the required dark output while err is raised.
  // ---------------------------------------------------------------------
  always_comb begin
    o_d   = O_POL;
    ov_d  = 1'b0;
    err_d = err_q;

    if (state_d != IDLE) begin
      o_d  = dec_oh ^ O_POL;
      ov_d = 1'b1;
    end

    // In SCAN in_ready is 0, so direct_accept is already false there;
    // err only moves on a real code acceptance and survives mode changes.
    if (direct_accept) begin
      err_d = dec_oor;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pos_q   <= '0;
      dwell_q <= '0;
      o_q     <= O_POL;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pos_q   <= pos_d;
      dwell_q <= dwell_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign O         = o_q;
  assign out_valid = ov_q;
  assign err       = err_q;
  assign scan_pos  = pos_q;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (IN_W=4, OUT_N=12, DWELL=3).
// Direct-mode vectors come from a table; scan walk, scan exit and
// asynchronous reset are hand-written sequences.
module tb_decoder_scan;

  localparam int IN_W  = 4;
  localparam int OUT_N = 12;
  localparam int DWELL = 3;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [0:OUT_N-1] POL = '1;
`else
  localparam logic [0:OUT_N-1] POL = '0;
`endif

  logic             clk;
  logic             reset_n;
  logic             mode;
  logic             in_valid;
  logic [IN_W-1:0]  in_code;
  logic             in_ready;
  logic [0:OUT_N-1] O;
  logic             out_valid;
  logic             err;
  logic [3:0]       scan_pos;

  decoder_scan #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N),
    .DWELL (DWELL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .err       (err),
    .scan_pos  (scan_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pin pattern: active-high one-hot of idx (none if idx < 0),
  // then the build's polarity.
  function automatic logic [0:OUT_N-1] exp_o(input int idx);
    logic [0:OUT_N-1] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v ^ POL;
  endfunction

  task automatic chk_all(input string tag, input int idx, input logic ov,
                         input logic er, input logic rdy, input int pos);
    chk({tag, "_O"},        32'(O),         32'(exp_o(idx)));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, "_err"},      32'(err),       32'(er));
    chk({tag, "_in_ready"}, 32'(in_ready),  32'(rdy));
    chk({tag, "_scan_pos"}, 32'(scan_pos),  32'(pos));
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic m, input logic v, input logic [IN_W-1:0] c);
    @(negedge clk);
    mode     = m;
    in_valid = v;
    in_code  = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            mode;
    logic            vld;
    logic [IN_W-1:0] code;
    int              idx;   // expected active position, -1 = none
    logic            ov;
    logic            er;
    logic            rdy;
    int              pos;
  } vec_t;

  vec_t vec [10];

  initial begin
    // mode vld code   idx ov er rdy pos
    vec[0] = '{1'b0, 1'b0, 4'd0,  -1, 1'b0, 1'b0, 1'b1, 0}; // idle, nothing
    vec[1] = '{1'b0, 1'b1, 4'd0,   0, 1'b1, 1'b0, 1'b1, 0}; // code 0
    vec[2] = '{1'b0, 1'b1, 4'd5,   5, 1'b1, 1'b0, 1'b1, 0}; // code 5
    vec[3] = '{1'b0, 1'b1, 4'd11, 11, 1'b1, 1'b0, 1'b1, 0}; // last legal code
    vec[4] = '{1'b0, 1'b1, 4'd13, -1, 1'b1, 1'b1, 1'b1, 0}; // out of range
    vec[5] = '{1'b0, 1'b0, 4'd7,  -1, 1'b1, 1'b1, 1'b1, 0}; // no accept: err held
    vec[6] = '{1'b0, 1'b1, 4'd2,   2, 1'b1, 1'b0, 1'b1, 0}; // in range clears err
    vec[7] = '{1'b0, 1'b0, 4'd9,   2, 1'b1, 1'b0, 1'b1, 0}; // hold
    vec[8] = '{1'b0, 1'b1, 4'd12, -1, 1'b1, 1'b1, 1'b1, 0}; // first illegal code
    vec[9] = '{1'b1, 1'b1, 4'd3,   0, 1'b1, 1'b1, 1'b0, 0}; // mode wins, err kept

    mode     = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    reset_n  = 1'b0;

    // Reset state (before any clock edge).
    #1;
    chk_all("reset", -1, 1'b0, 1'b0, 1'b1, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Direct-mode table, ending with the switch into scan.
    for (int i = 0; i < 10; i++) begin
      step(vec[i].mode, vec[i].vld, vec[i].code);
      chk_all($sformatf("vec%0d", i), vec[i].idx, vec[i].ov, vec[i].er,
              vec[i].rdy, vec[i].pos);
    end

    // Scan walk: k cycles after entry the position is (k / DWELL) mod OUT_N.
    // Runs past one full wrap (36 cycles) and stops with position 7 showing.
    for (int k = 1; k <= 57; k++) begin
      int p;
      p = (k / DWELL) % OUT_N;
      step(1'b1, 1'b1, 4'd6);
      chk_all($sformatf("scan%0d", k), p, 1'b1, 1'b1, 1'b0, p);
    end

    // Leave scan while at position 7.
    step(1'b0, 1'b0, 4'd0);
    chk_all("scan_exit", -1, 1'b0, 1'b1, 1'b1, 0);

    // Direct accept after scan.
    step(1'b0, 1'b1, 4'd4);
    chk_all("after_scan_code4", 4, 1'b1, 1'b0, 1'b1, 0);

    // Raise err, enter scan, then reset asynchronously between edges.
    step(1'b0, 1'b1, 4'd14);
    chk_all("code14", -1, 1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 4'd0);
    chk_all("scan_entry2", 0, 1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    chk_all("scan2_pos1", 1, 1'b1, 1'b1, 1'b0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", -1, 1'b0, 1'b0, 1'b1, 0);

    @(negedge clk);
    mode    = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset", -1, 1'b0, 1'b0, 1'b1, 0);

    // Throughput check after reset: back-to-back codes 3 then 10.
    step(1'b0, 1'b1, 4'd3);
    chk_all("b2b_code3", 3, 1'b1, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 4'd10);
    chk_all("b2b_code10", 10, 1'b1, 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_decoder_scan
